// File: rtl/div.sv
// Unsigned sequential restoring divider; PART_DATA_WIDTH quotient bits per cycle.
// rd_data = {remainder, quotient}; same write/read handshake as the mul block.
module div #(
  parameter int DATA_WIDTH      = 32,
  parameter int RES_WIDTH       = DATA_WIDTH*2,
  parameter int PART_DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  input  logic [DATA_WIDTH-1:0] wr_data_2,
  output logic [RES_WIDTH-1:0]  rd_data,
  output logic                  wr_ready,
  output logic                  rd_ready,
  output logic                  rd_val,
  output logic                  div_by_zero
);
  localparam int STEPS = DATA_WIDTH / PART_DATA_WIDTH;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] dvd_q;   // dividend bits shift out MSB-first, quotient bits shift in
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_WIDTH:0]   rem_n;
  logic [DATA_WIDTH-1:0] quo_n;

  // One extra remainder bit so the shifted partial remainder never overflows the compare.
  always_comb begin
    rem_n = {1'b0, rem_q};
    quo_n = dvd_q;
    for (int i = 0; i < PART_DATA_WIDTH; i++) begin
      rem_n = {rem_n[DATA_WIDTH-1:0], quo_n[DATA_WIDTH-1]};
      quo_n = {quo_n[DATA_WIDTH-2:0], 1'b0};
      if (rem_n >= {1'b0, dvs_q}) begin
        rem_n    = rem_n - {1'b0, dvs_q};
        quo_n[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_data     <= '0;
      rd_ready    <= 1'b0;
      rd_val      <= 1'b0;
      div_by_zero <= 1'b0;
      wr_ready    <= 1'b1;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      rd_val <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en && wr_ready) begin
            wr_ready <= 1'b0;
            if (wr_data_2 != '0) begin
              dvd_q       <= wr_data_1;
              dvs_q       <= wr_data_2;
              rem_q       <= '0;
              cnt_q       <= '0;
              div_by_zero <= 1'b0;
              state       <= CALC;
            end else begin
              // rd_ready follows one edge later, from the DONE branch below.
              rd_data     <= {wr_data_1, {DATA_WIDTH{1'b1}}};
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end
        end
        CALC: begin
          dvd_q <= quo_n;
          rem_q <= rem_n[DATA_WIDTH-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            rd_data  <= {rem_n[DATA_WIDTH-1:0], quo_n};
            rd_ready <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (rd_en && rd_ready) begin
            rd_ready <= 1'b0;
            rd_val   <= 1'b1;
            wr_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            rd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div.sv
// Directed bench for div: handshake timing, arithmetic vectors, divide-by-zero, ignored writes, reset abort.
module tb_div;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en, wr_en;
  logic [DW-1:0] wr_data_1, wr_data_2;
  logic [2*DW-1:0] rd_data;
  logic          wr_ready, rd_ready, rd_val, div_by_zero;

  int checks = 0;
  int errors = 0;

  div #(.DATA_WIDTH(DW), .RES_WIDTH(2*DW), .PART_DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .rd_data(rd_data),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_val(rd_val), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write, wait for rd_ready (bounded), check latency/result, then read and check rd_val.
  task automatic run(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW-1:0] exp_q, input logic [DW-1:0] exp_r,
                     input logic exp_dbz, input int exp_lat);
    int n;
    wr_data_1 = a; wr_data_2 = b; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (!rd_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_data"}, rd_data, {exp_r, exp_q});
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_rdval"}, 64'(rd_val), 64'd1);
  endtask

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; wr_data_1 = '0; wr_data_2 = '0;
    tick();
    reset = 1'b0;
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_rd_val", 64'(rd_val), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);

    // 100 / 7 with explicit cycle-by-cycle timing
    wr_data_1 = 32'd100; wr_data_2 = 32'd7; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t1_wr_ready_busy", 64'(wr_ready), 64'd0);
    tick(); tick(); tick();
    chk("t1_not_ready_yet", 64'(rd_ready), 64'd0);
    tick();
    chk("t1_ready", 64'(rd_ready), 64'd1);
    chk("t1_data", rd_data, {32'd2, 32'd14});
    chk("t1_dbz", 64'(div_by_zero), 64'd0);
    // wr_en alongside the consuming rd_en must be ignored
    rd_en = 1'b1; wr_en = 1'b1; wr_data_1 = 32'd9; wr_data_2 = 32'd3;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("t1_rd_val", 64'(rd_val), 64'd1);
    chk("t1_rd_ready_low", 64'(rd_ready), 64'd0);
    tick();
    chk("t1_rd_val_pulse", 64'(rd_val), 64'd0);
    chk("t1_wr_same_cycle_ignored", 64'(wr_ready), 64'd1);
    chk("t1_data_hold", rd_data, {32'd2, 32'd14});

    run("t2", 32'h00123456, 32'h100, 32'h1234, 32'h56, 1'b0, 4);
    run("t3a", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 4);
    run("t3b", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 4);
    run("t4", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
    tick();
    chk("t4_dbz_hold", 64'(div_by_zero), 64'd1);
    chk("t4_data_hold", rd_data, {32'd5, 32'hFFFFFFFF});
    run("t4_clear", 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 4);

    // wr_en and early rd_en during CALC are ignored
    wr_data_1 = 32'd100; wr_data_2 = 32'd7; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    wr_data_1 = 32'd50; wr_data_2 = 32'd3; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t5_no_early_rd_val", 64'(rd_val), 64'd0);
    chk("t5_no_early_ready", 64'(rd_ready), 64'd0);
    tick(); tick();
    chk("t5_ready", 64'(rd_ready), 64'd1);
    chk("t5_data", rd_data, {32'd2, 32'd14});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t5_rd_val", 64'(rd_val), 64'd1);

    // reset two cycles into CALC aborts the operation
    wr_data_1 = 32'd77; wr_data_2 = 32'd5; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rd_data", rd_data, 64'd0);
    chk("t6_rd_ready", 64'(rd_ready), 64'd0);
    chk("t6_rd_val", 64'(rd_val), 64'd0);
    chk("t6_dbz", 64'(div_by_zero), 64'd0);
    chk("t6_wr_ready", 64'(wr_ready), 64'd1);
    tick(); tick(); tick(); tick();
    chk("t6_stays_idle", 64'(rd_ready), 64'd0);
    run("t6_fresh", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
